cpu_core_param: RTL and testbench
=================================

# cpu_core_param

Parametrised multi-cycle successor to the 8-bit simple processor: a fetch/execute core with configurable data width, register count and program-counter width, plus a request/acknowledge instruction-memory port, branches and a halt state. It sits inside the Tiny Tapeout top-level wrapper. The wrapper maps `pc` to `uio_out` and `alu_out` to `uo_out`, and its testbench probes the debug outputs.

## Interface
- `DATA_W`, default 8: datapath and register width; legal range 8..32.
- `NREG`, default 8: register count; power of two, 4..16.
- `PC_W`, default 8: program-counter and instruction-address width; legal range 4..16.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `ena`, in, 1: high allows the core to advance. When low, the state, PC, registers, flags and outputs hold, and `reg_write` is 0.
- `imem_req`, out, 1: instruction fetch request.
- `imem_addr`, out, PC_W: fetch address; always equal to `pc`.
- `imem_ack`, in, 1: memory has `imem_rdata` valid this cycle.
- `imem_rdata`, in, 16: instruction word.
- `pc`, out, PC_W: program counter.
- `alu_out`, out, DATA_W: last ALU/LDI result, registered.
- `reg_write`, out, 1: one-cycle pulse on each register-file write.
- `dbg_rd`, out, clog2(NREG): destination index of the instruction in execute.
- `carry`, out, 1: carry/borrow flag.
- `halted`, out, 1: core is in HALT.

## Operation
- Instruction format is 16 bits: `op[15:12]`, `rd[11:8]`, `rs[7:4]`, `rt[3:0]`. `imm8` is `[7:0]`. Register indices use only the low clog2(NREG) bits of each field.
- R0 always reads 0. Writes to R0 are discarded, and `reg_write` still pulses.
- Opcodes:
  - 0 ADD: rd=rs+rt.
  - 1 SUB: rd=rs-rt.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SHL: rd=rs<<1, `carry` = shifted-out MSB.
  - 6 LDI: rd = imm8, zero-extended to DATA_W.
  - 7 BZ: if R[rd]==0, pc = imm8 (zero-extended or truncated to PC_W); otherwise pc+1.
  - 8 JMP: pc = imm8 (zero-extended or truncated to PC_W).
  - 15 HALT.
  - 9..14: NOP (pc+1 only).
- Arithmetic is modulo 2^DATA_W.
  - ADD sets `carry` = carry-out.
  - SUB sets `carry` = borrow (1 when rs<rt, unsigned).
  - Other opcodes leave `carry` unchanged.
- `alu_out` updates only for opcodes 0-6. It holds for all other opcodes.
- PC increments modulo 2^PC_W; PC 2^PC_W-1 wraps to 0.
- FSM states FETCH, EXEC, HALT; reset state is FETCH.
  - FETCH: `imem_req`=1 and `imem_addr`=`pc`, both held stable until ack. On an edge with `ena && imem_ack`, latch `imem_rdata` into the instruction register and go to EXEC.
  - EXEC: one cycle. Perform the write-back (`reg_write`=1 for opcodes 0-6), update PC and flags, then go to FETCH. HALT goes to HALT instead.
  - HALT: `halted`=1 and `imem_req`=0. The PC holds the HALT instruction's address. Exit only by reset.
- Reset values: `pc`=0, all registers 0, `alu_out`=0, `carry`=0, `reg_write`=0, `halted`=0, `dbg_rd`=0, instruction register 0. `imem_req`=1 in the first cycle after release.
- Reset asserted at any point, including mid-fetch with a pending ack or in HALT, overrides everything at that edge.
- `imem_ack` is ignored outside FETCH.

## Timing
- `imem_ack` may be combinational in the same cycle as `imem_req`; a zero-wait fetch costs 1 cycle.
- With zero-wait memory each instruction takes 2 cycles:
  - Instruction N (N=0,1,…) is latched at edge 2N+1 after reset release.
  - It retires at edge 2N+2, where register, `alu_out`, `carry` and `pc` become visible.
- Each wait cycle (`imem_ack`=0) adds one cycle; `imem_req` stays high throughout.
- `reg_write` is high for exactly the EXEC cycle.
- `ena` low for k cycles delays every later event by k cycles. An ack arriving while `ena`=0 is not taken.

## Test plan
- Ack tied high; program LDI R1,5; LDI R2,3; ADD R3,R1,R2; SUB R4,R2,R1; HALT. Required:
  - R3=8, R4=254 (DATA_W=8), `carry`=1.
  - `halted`=1 at edge 10, `pc` held at 4.
  - 4 `reg_write` pulses.
- DATA_W=16: LDI R1,0xFF; ADD R1,R1,R1 five times. Required: R1=0x1FE0, `carry`=0. Then SHL of a value with MSB set gives `carry`=1.
- BZ/JMP: LDI R1,0; BZ R1,6 → pc=6. At 6, LDI R1,1; BZ R1,0 falls through to pc=8. JMP 0xFF with PC_W=4 gives pc=15; the next instruction (NOP) wraps pc to 0.
- Fetch with 3 wait cycles: `imem_req` and `imem_addr` stable for 4 cycles; the instruction retires 5 cycles after fetch start. Toggle `ena` low for 2 cycles mid-EXEC → all outputs freeze, and retirement shifts by exactly 2.
- Write R0 via LDI R0,9 → `reg_write` pulses, R0 still reads 0, `alu_out`=9.
- Assert `rst_n`=0 during a wait state and again in HALT → next cycle `pc`=0, `halted`=0, registers 0, `imem_req`=1 after release.

Source files
------------

// File: rtl/cpu_core_param_if.sv
// cpu_core_param_if: instruction-memory request/acknowledge port
interface cpu_core_param_if #(parameter int PC_W = 8);
   logic            req;
   logic [PC_W-1:0] addr;
   logic            ack;
   logic [15:0]     rdata;
   modport master (output req, addr, input ack, rdata);
   modport slave (input req, addr, output ack, rdata);
endinterface

// File: rtl/cpu_core_param.sv
// cpu_core_param: parametrised fetch/execute core with req/ack instruction port, branches and halt
module cpu_core_param #(
   parameter int DATA_W = 8,
   parameter int NREG   = 8,
   parameter int PC_W   = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ena,
   cpu_core_param_if.master        imem,
   output logic [PC_W-1:0]         pc,
   output logic [DATA_W-1:0]       alu_out,
   output logic                    reg_write,
   output logic [$clog2(NREG)-1:0] dbg_rd,
   output logic                    carry,
   output logic                    halted
);
   localparam int RW = $clog2(NREG);
   typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
   state_t            state_q, state_d;
   logic [15:0]       ir_q, ir_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0] alu_q, alu_d;
   logic              carry_q, carry_d;
   logic [DATA_W-1:0] rf_q [NREG];
   logic [DATA_W-1:0] rf_d [NREG];
   logic [3:0]        op;
   logic [RW-1:0]     rd, rs, rt;
   logic [DATA_W-1:0] a, b, d, imm;
   logic [PC_W-1:0]   target, pc_inc;
   logic [DATA_W:0]   res;
   logic              take, exec, wr;
   assign op     = ir_q[15:12];
   assign rd     = ir_q[8 +: RW];
   assign rs     = ir_q[4 +: RW];
   assign rt     = ir_q[0 +: RW];
   assign a      = rf_q[rs];
   assign b      = rf_q[rt];
   assign d      = rf_q[rd];
   assign imm    = DATA_W'(ir_q[7:0]);
   assign target = PC_W'(ir_q[7:0]);
   assign pc_inc = pc_q + PC_W'(1);
   assign take   = ena && state_q == FETCH && imem.ack;
   assign exec   = ena && state_q == EXEC;
   assign wr     = exec && op <= 4'd6;
   always_ff @(posedge clk)
      if (!rst_n) state_q <= FETCH;
      else state_q <= state_d;
   always_comb begin
      state_d = !ena ? state_q
              : state_q == FETCH ? (imem.ack ? EXEC : FETCH)
              : state_q == EXEC ? (op == 4'hF ? HALT : FETCH)
              : HALT;
   end
   // the top result bit is the new carry; ops that keep carry feed carry_q back through it
   always_comb begin
      res = op == 4'd0 ? {1'b0, a} + {1'b0, b}
          : op == 4'd1 ? {1'b0, a} - {1'b0, b}
          : op == 4'd2 ? {carry_q, a & b}
          : op == 4'd3 ? {carry_q, a | b}
          : op == 4'd4 ? {carry_q, a ^ b}
          : op == 4'd5 ? {a, 1'b0}
          : {carry_q, imm};
      ir_d    = take ? imem.rdata : ir_q;
      alu_d   = wr ? res[DATA_W-1:0] : alu_q;
      carry_d = wr ? res[DATA_W] : carry_q;
      pc_d    = !exec ? pc_q
              : op == 4'd7 ? (d == '0 ? target : pc_inc)
              : op == 4'd8 ? target
              : op == 4'hF ? pc_q
              : pc_inc;
      rf_d = rf_q;
      if (wr && rd != '0) rf_d[rd] = res[DATA_W-1:0];
   end
   always_ff @(posedge clk)
      if (!rst_n) begin
         ir_q    <= '0;
         pc_q    <= '0;
         alu_q   <= '0;
         carry_q <= 1'b0;
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else begin
         ir_q    <= ir_d;
         pc_q    <= pc_d;
         alu_q   <= alu_d;
         carry_q <= carry_d;
         rf_q    <= rf_d;
      end
   always_comb begin
      imem.req  = state_q == FETCH;
      imem.addr = pc_q;
      reg_write = wr;
      halted    = state_q == HALT;
      dbg_rd    = rd;
      pc        = pc_q;
      alu_out   = alu_q;
      carry     = carry_q;
   end
endmodule

// File: tb/tb_cpu_core_param.sv
// tb_cpu_core_param: scoreboard bench with an instruction-level reference model
module tb_cpu_core_param;
   localparam int DW = 16, NR = 8, PW = 4;
   typedef struct packed {
      logic [PW-1:0] pc;
      logic [DW-1:0] alu;
      logic          c;
      logic          wr;
      logic [2:0]    rd;
      logic          h;
   } ev_t;
   logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, ack_en = 1'b1;
   logic [15:0]   mem [16];
   logic [PW-1:0] pc;
   logic [DW-1:0] alu_out;
   logic          reg_write, carry, halted;
   logic [2:0]    dbg_rd;
   ev_t           exp_q[$];
   ev_t           mon_e;
   logic          pending = 1'b0;
   int            vectors = 0, miscompares = 0, pulses;
   cpu_core_param_if #(.PC_W(PW)) bus();
   assign bus.ack   = ack_en;
   assign bus.rdata = mem[bus.addr];
   cpu_core_param #(.DATA_W(DW), .NREG(NR), .PC_W(PW)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .imem(bus), .pc(pc), .alu_out(alu_out),
      .reg_write(reg_write), .dbg_rd(dbg_rd), .carry(carry), .halted(halted)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask
   task automatic model();
      logic [DW-1:0] r [NR];
      logic [DW-1:0] alu = '0;
      logic [15:0]   ins;
      bit            c = 1'b0;
      longint        a, b, res, m;
      int            p, npc, op, rd, rs, rt;
      ev_t           e;
      m = longint'(1) << DW;
      p = 0;
      for (int i = 0; i < NR; i++) r[i] = '0;
      for (int n = 0; n < 100; n++) begin
         ins = mem[p];
         op  = ins[15:12];
         rd  = ins[11:8] % NR;
         rs  = ins[7:4] % NR;
         rt  = ins[3:0] % NR;
         a   = r[rs];
         b   = r[rt];
         res = 0;
         npc = (p + 1) % (1 << PW);
         case (op)
            0: begin res = a + b; c = res >= m; end
            1: begin res = a - b; c = a < b; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin res = 2 * a; c = a >= m / 2; end
            6: res = ins[7:0];
            7: if (r[rd] == 0) npc = ins[7:0] % (1 << PW);
            8: npc = ins[7:0] % (1 << PW);
            15: npc = p;
            default: ;
         endcase
         if (op <= 6) begin
            alu = DW'(((res % m) + m) % m);
            if (rd != 0) r[rd] = alu;
         end
         e.pc  = PW'(npc);
         e.alu = alu;
         e.c   = c;
         e.wr  = op <= 6;
         e.rd  = 3'(rd);
         e.h   = op == 15;
         exp_q.push_back(e);
         p = npc;
         if (op == 15) break;
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #2;
   endtask
   task automatic start();
      rst_n = 1'b0;
      exp_q.delete();
      tick();
      tick();
      model();
   endtask
   task automatic run(input int pa, input int pe);
      int n = 0;
      rst_n = 1'b1;
      while (!(halted && exp_q.size() == 0) && n < 3000) begin
         tick();
         n++;
         ena    = $urandom_range(0, 99) < pe;
         ack_en = $urandom_range(0, 99) < pa;
      end
      chk("run_done", n < 3000, 1);
      ena    = 1'b1;
      ack_en = 1'b1;
   endtask
   initial forever begin
      @(negedge clk);
      if (!rst_n) pending = 1'b0;
      else begin
         if (pending) begin
            mon_e = exp_q.pop_front();
            chk("pc", pc, mon_e.pc);
            chk("alu_out", alu_out, mon_e.alu);
            chk("carry", carry, mon_e.c);
            chk("halted", halted, mon_e.h);
            pending = 1'b0;
         end
         if (!bus.req && !halted) begin
            if (!ena) chk("reg_write_stall", reg_write, 0);
            else begin
               chk("exec_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  chk("reg_write", reg_write, exp_q[0].wr);
                  chk("dbg_rd", dbg_rd, exp_q[0].rd);
                  pending = 1'b1;
               end
            end
         end
      end
   end
   initial begin
      logic [15:0] ins;
      mem = '{default: 16'hF000};
      mem[0] = 16'h6105; mem[1] = 16'h6203; mem[2] = 16'h0312; mem[3] = 16'h1421;
      start();
      chk("rst_pc", pc, 0);
      chk("rst_alu", alu_out, 0);
      chk("rst_carry", carry, 0);
      chk("rst_halted", halted, 0);
      chk("rst_reg_write", reg_write, 0);
      chk("rst_dbg_rd", dbg_rd, 0);
      chk("rst_req", bus.req, 1);
      rst_n  = 1'b1;
      pulses = 0;
      for (int e = 1; e <= 10; e++) begin
         tick();
         pulses += int'(reg_write);
         if (e == 9) chk("halted_e9", halted, 0);
      end
      chk("halted_e10", halted, 1);
      chk("halt_pc", pc, 4);
      chk("pulses", pulses, 4);
      chk("sub_carry", carry, 1);
      chk("sub_alu", alu_out, 16'hFFFE);
      repeat (3) tick();
      chk("halt_hold_pc", pc, 4);
      chk("halt_req", bus.req, 0);
      rst_n = 1'b0;
      exp_q.delete();
      tick();
      chk("rsth_pc", pc, 0);
      chk("rsth_halted", halted, 0);
      chk("rsth_req", bus.req, 1);
      chk("rsth_alu", alu_out, 0);
      mem = '{default: 16'hF000};
      mem[0] = 16'h6107; mem[1] = 16'h6201;
      start();
      ack_en = 1'b0;
      rst_n  = 1'b1;
      chk("wait_req", bus.req, 1);
      chk("wait_addr", bus.addr, 0);
      for (int e = 1; e <= 3; e++) begin
         tick();
         chk("wait_req", bus.req, 1);
         chk("wait_addr", bus.addr, 0);
      end
      ack_en = 1'b1;
      tick();
      chk("wait_exec_rw", reg_write, 1);
      chk("wait_exec_alu", alu_out, 0);
      tick();
      chk("wait_retire_alu", alu_out, 7);
      chk("wait_retire_pc", pc, 1);
      tick();
      ena = 1'b0;
      for (int e = 0; e < 2; e++) begin
         tick();
         chk("stall_rw", reg_write, 0);
         chk("stall_alu", alu_out, 7);
         chk("stall_pc", pc, 1);
         chk("stall_req", bus.req, 0);
      end
      ena = 1'b1;
      tick();
      chk("stall_retire_alu", alu_out, 1);
      chk("stall_retire_pc", pc, 2);
      ena = 1'b0;
      tick();
      chk("noena_ack_req", bus.req, 1);
      chk("noena_ack_halted", halted, 0);
      ena = 1'b1;
      tick();
      chk("late_exec_req", bus.req, 0);
      tick();
      chk("late_halted", halted, 1);
      mem = '{default: 16'hF000};
      mem[0] = 16'h6105; mem[1] = 16'h6203; mem[2] = 16'h0312; mem[3] = 16'h1421;
      start();
      rst_n = 1'b1;
      repeat (8) tick();
      ack_en = 1'b0;
      tick();
      tick();
      chk("rstw_wait_req", bus.req, 1);
      ack_en = 1'b1;
      rst_n  = 1'b0;
      exp_q.delete();
      tick();
      chk("rstw_pc", pc, 0);
      chk("rstw_halted", halted, 0);
      chk("rstw_rw", reg_write, 0);
      chk("rstw_alu", alu_out, 0);
      chk("rstw_carry", carry, 0);
      chk("rstw_req", bus.req, 1);
      mem = '{default: 16'hF000};
      mem[0] = 16'h6009; mem[1] = 16'h0500; mem[2] = 16'h0634;
      start();
      rst_n = 1'b1;
      tick();
      chk("r0_rw", reg_write, 1);
      chk("r0_dbg_rd", dbg_rd, 0);
      tick();
      chk("r0_alu", alu_out, 9);
      run(100, 100);
      mem = '{default: 16'hF000};
      mem[0] = 16'h61FF;
      for (int i = 1; i <= 5; i++) mem[i] = 16'h0111;
      for (int i = 6; i <= 8; i++) mem[i] = 16'h5110;
      mem[9] = 16'h5210;
      start();
      run(70, 80);
      chk("shl_alu", alu_out, 16'hFE00);
      chk("shl_carry", carry, 1);
      mem = '{default: 16'hF000};
      mem[0] = 16'h7104; mem[4] = 16'h6100; mem[5] = 16'h7106; mem[6] = 16'h6101;
      mem[7] = 16'h7100; mem[8] = 16'h80FF; mem[15] = 16'h9000;
      start();
      run(100, 100);
      chk("br_pc", pc, 1);
      start();
      run(50, 70);
      chk("br_pc_rand", pc, 1);
      repeat (30) begin
         mem = '{default: 16'hF000};
         for (int p = 0; p < 14; p++) begin
            ins = 16'($urandom);
            if (ins[15:12] == 4'hF) ins[15:12] = 4'h6;
            if (ins[15:12] == 4'h7 || ins[15:12] == 4'h8)
               ins[7:0] = 8'($urandom_range(14, p + 1) + 16 * $urandom_range(15, 0));
            mem[p] = ins;
         end
         start();
         run($urandom_range(40, 100), $urandom_range(50, 100));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
